// File: rtl/lockpick_vault.sv
`default_nettype none
// ============================================================================
// lockpick_vault
// Two byte-serial keys are XORed, hashed by an S-box mixer, and checked
// against TARGET; a 4-byte verdict goes out on a valid/ready stream.
// Revision: 1.0
// ============================================================================
module lockpick_vault #(
    parameter int          KEY_BYTES      = 32,
    parameter int          ROUNDS         = 3,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          LOCKOUT_CYCLES = 1024,
    parameter logic [63:0] TARGET         = 64'hCAFEBABE_0BADBEEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [1:0] status,
    output logic [2:0] attempts_left,
    output logic       busy
);
    localparam int IDX_W  = $clog2(KEY_BYTES) + 1;
    localparam int SEL_W  = $clog2(KEY_BYTES);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_WRONG  = 2'b01;
    localparam logic [1:0] ST_WIN    = 2'b10;
    localparam logic [1:0] ST_LOCKED = 2'b11;

    // AES forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        HASH    = 3'd3,
        COMPARE = 3'd4,
        SEND    = 3'd5,
        LOCKED  = 3'd6
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        key [KEY_BYTES];
    logic [IDX_W-1:0]  byte_idx;
    logic [SEL_W-1:0]  sel;
    logic [3:0]        round_idx;
    logic [63:0]       digest;
    logic [31:0]       msg;
    logic [1:0]        send_idx;
    logic [LOCK_W-1:0] lock_cnt;
    logic              beat;
    logic              last_byte;
    logic              last_step;
    logic [7:0]        mix_in;

    assign sel       = byte_idx[SEL_W-1:0];
    assign beat      = in_valid && in_ready;
    assign last_byte = (byte_idx == IDX_W'(KEY_BYTES - 1));
    assign last_step = last_byte && (round_idx == 4'(ROUNDS - 1));
    assign mix_in    = key[sel] ^ 8'(byte_idx) ^ {round_idx, 4'h0};

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) state_next = LOAD_A;
            LOAD_A: begin
                in_ready = 1'b1;
                if (beat && last_byte) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (beat && last_byte) state_next = HASH;
            end
            HASH:    if (last_step) state_next = COMPARE;
            COMPARE: state_next = SEND;
            SEND: begin
                out_valid = 1'b1;
                out_data  = msg[{send_idx, 3'b000} +: 8];
                if (out_ready && (send_idx == 2'd3)) begin
                    case (status)
                        ST_WIN:   state_next = IDLE;
                        ST_WRONG: state_next = LOAD_A;
                        default:  state_next = LOCKED;
                    endcase
                end
            end
            LOCKED:  if (lock_cnt <= LOCK_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            for (int i = 0; i < KEY_BYTES; i++) key[i] <= 8'h00;
            byte_idx      <= '0;
            round_idx     <= 4'd0;
            digest        <= 64'h0;
            msg           <= 32'h0;
            send_idx      <= 2'd0;
            lock_cnt      <= '0;
            status        <= ST_IDLE;
            attempts_left <= 3'(MAX_ATTEMPTS);
        end else begin
            state <= state_next;
            case (state)
                LOAD_A: if (beat) begin
                    key[sel] <= in_data;
                    byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
                end
                LOAD_B: if (beat) begin
                    key[sel] <= key[sel] ^ in_data;
                    byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
                    if (last_byte) begin
                        digest    <= 64'h0;
                        round_idx <= 4'd0;
                    end
                end
                HASH: begin
                    digest <= {digest[58:0], digest[63:59]} ^ {56'h0, sbox(mix_in)};
                    if (last_byte) begin
                        byte_idx  <= '0;
                        round_idx <= round_idx + 4'd1;
                    end else begin
                        byte_idx  <= byte_idx + IDX_W'(1);
                    end
                end
                COMPARE: begin
                    send_idx <= 2'd0;
                    if (digest == TARGET) begin
                        status <= ST_WIN;
                        msg    <= 32'hFACEFACE;
                    end else if (attempts_left > 3'd1) begin
                        attempts_left <= attempts_left - 3'd1;
                        status        <= ST_WRONG;
                        msg           <= 32'hBAD0BAD0;
                    end else begin
                        attempts_left <= 3'd0;
                        status        <= ST_LOCKED;
                        msg           <= 32'hDEADDEAD;
                    end
                end
                SEND: if (out_ready) begin
                    send_idx <= send_idx + 2'd1;
                    if (send_idx == 2'd3) begin
                        case (status)
                            ST_WIN: begin
                                status        <= ST_IDLE;
                                attempts_left <= 3'(MAX_ATTEMPTS);
                            end
                            ST_LOCKED: lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
                            default: ;
                        endcase
                    end
                end
                LOCKED: begin
                    lock_cnt <= lock_cnt - LOCK_W'(1);
                    if (lock_cnt <= LOCK_W'(1)) begin
                        status        <= ST_IDLE;
                        attempts_left <= 3'(MAX_ATTEMPTS);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lockpick_vault.sv
`default_nettype none
// ============================================================================
// tb_lockpick_vault
// Scoreboarded bench: instance 0 runs the session scenarios, instances 1..3
// cover other key lengths and round counts against an independent digest model.
// Revision: 1.0
// ============================================================================
module tb_lockpick_vault;
    localparam int LOCK_CYC = 20;

    function automatic int nb_of(input int g);
        case (g)
            0: return 4;
            1: return 2;
            2: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int nr_of(input int g);
        case (g)
            0: return 1;
            1: return 15;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic        start_a     [4];
    logic        in_valid_a  [4];
    logic [7:0]  in_data_a   [4];
    logic        in_ready_a  [4];
    logic        out_valid_a [4];
    logic [7:0]  out_data_a  [4];
    logic        out_ready_a [4];
    logic [1:0]  status_a    [4];
    logic [2:0]  attempts_a  [4];
    logic        busy_a      [4];
    logic [63:0] dig_a       [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        lockpick_vault #(
            .KEY_BYTES     (nb_of(g)),
            .ROUNDS        (nr_of(g)),
            .MAX_ATTEMPTS  (3),
            .LOCKOUT_CYCLES(LOCK_CYC),
            .TARGET        ((g == 0) ? 64'h0000_0000_0030_0003 : 64'hCAFEBABE_0BADBEEF)
        ) u (
            .clk          (clk),
            .rst          (rst),
            .start        (start_a[g]),
            .in_valid     (in_valid_a[g]),
            .in_data      (in_data_a[g]),
            .in_ready     (in_ready_a[g]),
            .out_valid    (out_valid_a[g]),
            .out_data     (out_data_a[g]),
            .out_ready    (out_ready_a[g]),
            .status       (status_a[g]),
            .attempts_left(attempts_a[g]),
            .busy         (busy_a[g])
        );
        assign dig_a[g] = u.digest;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] sbox_tb [256];
    logic [7:0] win_a [64];
    logic [7:0] bad_a [64];
    logic [7:0] zero_b [64];
    logic [7:0] ra [64];
    logic [7:0] rb [64];
    logic [7:0] rc [64];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // S-box derived from GF(2^8) inversion plus the AES affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [63:0] model_digest(input logic [7:0] k[64], input int nb, input int nr);
        logic [63:0] h = 64'h0;
        for (int r = 0; r < nr; r++)
            for (int i = 0; i < nb; i++)
                h = {h[58:0], h[63:59]} ^ {56'h0, sbox_tb[k[i] ^ 8'(i) ^ 8'(r << 4)]};
        return h;
    endfunction

    task automatic push_msg(input logic [31:0] m);
        for (int i = 0; i < 4; i++) exp_q.push_back(m[i*8 +: 8]);
    endtask

    task automatic start_session(input int j);
        start_a[j] = 1'b1;
        @(posedge clk); #1;
        start_a[j] = 1'b0;
    endtask

    task automatic load_key(input int j, input logic [7:0] k[64], input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                for (int g2 = 0; g2 < 3 && $urandom_range(0, 1) == 1; g2++) begin
                    in_valid_a[j] = 1'b0;
                    in_data_a[j]  = 8'($urandom);
                    @(posedge clk); #1;
                end
            in_valid_a[j] = 1'b1;
            in_data_a[j]  = k[i];
            @(posedge clk); #1;
        end
        in_valid_a[j] = 1'b0;
    endtask

    task automatic wait_ov(input int j);
        for (int c = 0; c < 3000 && !out_valid_a[j]; c++) @(negedge clk);
        chk("wait_out_valid", out_valid_a[j], 1);
    endtask

    task automatic wait_ld(input int j);
        for (int c = 0; c < 3000 && !(in_ready_a[j] && !out_valid_a[j]); c++) @(negedge clk);
        chk("wait_load_a", in_ready_a[j], 1);
    endtask

    task automatic wait_idle(input int j);
        for (int c = 0; c < 3000 && busy_a[j]; c++) @(negedge clk);
        chk("wait_idle", busy_a[j], 0);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_in_ready"},  in_ready_a[0],  0);
        chk({nm, "_out_valid"}, out_valid_a[0], 0);
        chk({nm, "_out_data"},  out_data_a[0],  0);
        chk({nm, "_status"},    status_a[0],    0);
        chk({nm, "_attempts"},  attempts_a[0],  3);
        chk({nm, "_busy"},      busy_a[0],      0);
    endtask

    // scoreboard monitor: every accepted verdict byte must match the queue head
    always @(negedge clk) begin
        if (out_valid_a[0] && out_ready_a[0]) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_byte: got %h expected none", out_data_a[0]);
            end else begin
                chk("sb_byte", out_data_a[0], exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            start_a[j] = 0; in_valid_a[j] = 0; in_data_a[j] = 0; out_ready_a[j] = 1;
        end
        for (int i = 0; i < 64; i++) begin
            win_a[i] = (i < 4) ? 8'(i) : 8'h00;
            bad_a[i] = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'h00;
            zero_b[i] = 8'h00;
        end
        build_sbox();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // T5: other geometries, gappy loads, digest against model
        for (int j = 1; j < 4; j++) begin
            for (int i = 0; i < 64; i++) begin
                ra[i] = 8'($urandom); rb[i] = 8'($urandom); rc[i] = ra[i] ^ rb[i];
            end
            start_session(j);
            load_key(j, ra, nb_of(j), 1'b1);
            load_key(j, rb, nb_of(j), 1'b1);
            wait_ov(j);
            chk("t5_digest", dig_a[j], model_digest(rc, nb_of(j), nr_of(j)));
        end

        // T1: win, exact HASH length
        push_msg(32'hFACEFACE);
        start_session(0);
        load_key(0, win_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        repeat (5) @(negedge clk);
        chk("t1_no_verdict_in_compare", out_valid_a[0], 0);
        @(negedge clk);
        chk("t1_verdict_starts", out_valid_a[0], 1);
        chk("t1_status_win", status_a[0], 2'b10);
        wait_idle(0);
        chk("t1_status_idle", status_a[0], 2'b00);
        chk("t1_attempts", attempts_a[0], 3);

        // T2: wrong key
        push_msg(32'hBAD0BAD0);
        start_session(0);
        load_key(0, bad_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ld(0);
        chk("t2_status", status_a[0], 2'b01);
        chk("t2_attempts", attempts_a[0], 2);
        chk("t2_busy", busy_a[0], 1);

        // T3: exhaust attempts, lockout timing, start ignored while locked
        push_msg(32'hBAD0BAD0);
        load_key(0, bad_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ld(0);
        chk("t3_attempts_1", attempts_a[0], 1);
        push_msg(32'hDEADDEAD);
        load_key(0, bad_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ov(0);
        chk("t3_status_locked", status_a[0], 2'b11);
        chk("t3_attempts_0", attempts_a[0], 0);
        repeat (4) @(negedge clk);
        chk("t3_locked_no_valid", out_valid_a[0], 0);
        chk("t3_locked_busy", busy_a[0], 1);
        start_a[0] = 1'b1; in_valid_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        start_a[0] = 1'b0; in_valid_a[0] = 1'b0;
        repeat (LOCK_CYC - 4) @(negedge clk);
        chk("t3_still_locked", busy_a[0], 1);
        chk("t3_still_status", status_a[0], 2'b11);
        @(negedge clk);
        chk("t3_rearm_idle", busy_a[0], 0);
        chk("t3_rearm_attempts", attempts_a[0], 3);
        chk("t3_rearm_status", status_a[0], 2'b00);

        // T4: backpressure on byte 1
        push_msg(32'hFACEFACE);
        start_session(0);
        load_key(0, win_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ov(0);
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_data", out_data_a[0], 8'hFA);
            chk("t4_hold_valid", out_valid_a[0], 1);
        end
        @(posedge clk); #1;
        out_ready_a[0] = 1'b1;
        wait_idle(0);
        chk("t4_sb_empty", exp_q.size(), 0);

        // T6: reset mid-HASH (with a used attempt) and mid-SEND
        push_msg(32'hBAD0BAD0);
        start_session(0);
        load_key(0, bad_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ld(0);
        chk("t6_attempts_2", attempts_a[0], 2);
        load_key(0, win_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6_hash_rst");
        rst = 1'b0;
        exp_q.push_back(8'hCE);
        start_session(0);
        load_key(0, win_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ov(0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6_send_rst");
        rst = 1'b0;
        push_msg(32'hFACEFACE);
        start_session(0);
        load_key(0, win_a, 4, 1'b0);
        load_key(0, zero_b, 4, 1'b0);
        wait_ov(0);
        chk("t6_fresh_win", status_a[0], 2'b10);
        wait_idle(0);
        chk("t6_fresh_attempts", attempts_a[0], 3);
        chk("t6_sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
